// File: rtl/reaction_sequencer.sv
// -----------------------------------------------------------------------------
// reaction_sequencer
//
// Controller for the reaction-timer datapath. Runs one trial at a time:
//   start -> random wait (ARMED) -> go lamp (GO) -> capture at stop (DONE).
// A stop press before go ends the trial with the early flag set. A missing
// stop ends the trial with the timeout flag set after TIMEOUT_MS ms.
//
// Time is kept with a millisecond tick. The tick is a clock enable from a
// prescaler and is never used as a clock. The random part of the wait comes
// from a free-running 16-bit Fibonacci LFSR (taps 16,14,13,11).
//
// Ports
//   clk          in   clock
//   reset        in   asynchronous, active-high
//   start        in   start button, synchronised level (edge detected here)
//   stop         in   reaction button, synchronised level (edge detected here)
//   go           out  high while in GO
//   busy         out  high in ARMED or GO
//   result_ms    out  captured reaction time in ms (0 after early press)
//   result_valid out  one-cycle pulse on the first cycle in DONE
//   early        out  last trial ended by a stop press during ARMED
//   timeout      out  last trial ran out of reaction window
//   state_dbg    out  current FSM state, for checkers and debug
//
// Result handshake: result_valid is a strobe with no ready. result_ms,
// early and timeout are stable from the strobe cycle until the next trial
// starts, so a consumer may sample them on the strobe or at any later time.
// -----------------------------------------------------------------------------
module reaction_sequencer #(
  parameter int          CLK_DIV          = 10,
  parameter int          DELAY_MIN        = 2000,
  parameter int          DELAY_RANGE_BITS = 10,
  parameter int          TIMEOUT_MS       = 9999,
  parameter int          CNT_W            = 16,
  parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  output logic             go,
  output logic             busy,
  output logic [CNT_W-1:0] result_ms,
  output logic             result_valid,
  output logic             early,
  output logic             timeout,
  output logic [1:0]       state_dbg
);

  localparam int PS_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  // Mask selecting the random add-on bits of the LFSR; zero bits means
  // the wait is exactly DELAY_MIN.
  localparam logic [15:0] RAND_MASK =
    (DELAY_RANGE_BITS == 0) ? 16'd0 : 16'((32'd1 << DELAY_RANGE_BITS) - 32'd1);

  localparam logic [PS_W-1:0]  PS_LAST      = PS_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL  = CNT_W'(TIMEOUT_MS);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_MS - 1);
  localparam logic [CNT_W-1:0] DELAY_BASE   = CNT_W'(DELAY_MIN);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_GO    = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t             state_q;
  logic               start_q;
  logic               stop_q;
  logic [15:0]        lfsr_q;
  logic [PS_W-1:0]    presc_q;
  logic [CNT_W-1:0]   delay_q;
  logic [CNT_W-1:0]   elapsed_q;
  logic [CNT_W-1:0]   result_q;
  logic               result_valid_q;
  logic               early_q;
  logic               timeout_q;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic               start_e;
  logic               stop_e;
  logic [15:0]        lfsr_d;
  logic               timing_state;
  logic               presc_last;
  logic               tick;
  logic [15:0]        rand_part;
  logic [CNT_W-1:0]   delay_init;

  assign start_e = start & ~start_q;
  assign stop_e  = stop  & ~stop_q;

  // Fibonacci LFSR, taps 16,14,13,11 (bit indices 15,13,12,10).
  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  assign timing_state = (state_q == S_ARMED) || (state_q == S_GO);
  assign presc_last   = (presc_q == PS_LAST);
  assign tick         = presc_last && timing_state;

  assign rand_part  = lfsr_q & RAND_MASK;
  assign delay_init = DELAY_BASE + CNT_W'(rand_part);

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      start_q        <= 1'b0;
      stop_q         <= 1'b0;
      lfsr_q         <= LFSR_SEED;
      presc_q        <= '0;
      delay_q        <= '0;
      elapsed_q      <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      early_q        <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      start_q        <= start;
      stop_q         <= stop;
      lfsr_q         <= lfsr_d;
      result_valid_q <= 1'b0;

      // The prescaler only runs while a trial is being timed. Entering
      // ARMED or GO forces it back to zero below so the first ms is full.
      if (timing_state) begin
        presc_q <= presc_last ? '0 : presc_q + 1'b1;
      end else begin
        presc_q <= '0;
      end

      case (state_q)
        S_IDLE, S_DONE: begin
          // Start beats a simultaneous stop; stop alone is ignored here.
          if (start_e) begin
            state_q   <= S_ARMED;
            delay_q   <= delay_init;
            early_q   <= 1'b0;
            timeout_q <= 1'b0;
            result_q  <= '0;
            presc_q   <= '0;
          end
        end

        S_ARMED: begin
          if (stop_e) begin
            state_q        <= S_DONE;
            early_q        <= 1'b1;
            result_q       <= '0;
            result_valid_q <= 1'b1;
          end else if (delay_q == '0) begin
            // Zero wait only happens on entry; go on the next edge.
            state_q   <= S_GO;
            elapsed_q <= '0;
            presc_q   <= '0;
          end else if (tick) begin
            delay_q <= delay_q - 1'b1;
            if (delay_q == CNT_W'(1)) begin
              state_q   <= S_GO;
              elapsed_q <= '0;
              presc_q   <= '0;
            end
          end
        end

        S_GO: begin
          // Stop is checked before the tick so a coincident tick does not
          // count: only whole elapsed milliseconds are reported.
          if (stop_e) begin
            state_q        <= S_DONE;
            result_q       <= elapsed_q;
            result_valid_q <= 1'b1;
          end else if (tick) begin
            if (elapsed_q == TIMEOUT_LAST) begin
              state_q        <= S_DONE;
              timeout_q      <= 1'b1;
              result_q       <= TIMEOUT_VAL;
              result_valid_q <= 1'b1;
            end else begin
              elapsed_q <= elapsed_q + 1'b1;
            end
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from registers only, no path from the button inputs.
  // ---------------------------------------------------------------------------
  assign go           = (state_q == S_GO);
  assign busy         = (state_q == S_ARMED) || (state_q == S_GO);
  assign result_ms    = result_q;
  assign result_valid = result_valid_q;
  assign early        = early_q;
  assign timeout      = timeout_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_reaction_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reaction_sequencer
//
// Two instances of reaction_sequencer share clock and reset: one with no
// random wait (fixed 5 ms) and one with a 4-bit random add-on. Expected
// timings come from a trial-level model: go rises DELAY*CLK_DIV edges after
// the start is taken, and a stop sampled s edges after go reports
// (s-1)/CLK_DIV whole milliseconds, capped by the timeout.
// -----------------------------------------------------------------------------
module tb_reaction_sequencer;

  localparam int          CLK_DIV    = 4;
  localparam int          DELAY_MIN  = 5;
  localparam int          TIMEOUT_MS = 20;
  localparam int          CNT_W      = 16;
  localparam logic [15:0] SEED       = 16'hACE1;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic             start = 1'b0, stop = 1'b0;
  logic             go, busy, result_valid, early, timeout;
  logic [CNT_W-1:0] result_ms;
  logic [1:0]       state_dbg;

  logic             start_r = 1'b0, stop_r = 1'b0;
  logic             go_r, busy_r, result_valid_r, early_r, timeout_r;
  logic [CNT_W-1:0] result_ms_r;
  logic [1:0]       state_dbg_r;

  reaction_sequencer #(
    .CLK_DIV(CLK_DIV), .DELAY_MIN(DELAY_MIN), .DELAY_RANGE_BITS(0),
    .TIMEOUT_MS(TIMEOUT_MS), .CNT_W(CNT_W), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .go(go), .busy(busy), .result_ms(result_ms), .result_valid(result_valid),
    .early(early), .timeout(timeout), .state_dbg(state_dbg)
  );

  reaction_sequencer #(
    .CLK_DIV(CLK_DIV), .DELAY_MIN(DELAY_MIN), .DELAY_RANGE_BITS(4),
    .TIMEOUT_MS(TIMEOUT_MS), .CNT_W(CNT_W), .LFSR_SEED(SEED)
  ) dut_r (
    .clk(clk), .reset(reset), .start(start_r), .stop(stop_r),
    .go(go_r), .busy(busy_r), .result_ms(result_ms_r), .result_valid(result_valid_r),
    .early(early_r), .timeout(timeout_r), .state_dbg(state_dbg_r)
  );

  // Reference LFSR: the random add-on is taken from its value in the cycle
  // the start edge is sampled.
  logic [15:0] m_lfsr;
  always @(posedge clk or posedge reset) begin
    if (reset) m_lfsr <= SEED;
    else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int tests  = 0;
  int failed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Counts edges until go is seen high; bounded so a stuck DUT still ends.
  task automatic wait_go(input bit use_r, output int n);
    n = 0;
    while (((use_r ? go_r : go) !== 1'b1) && n < 400) begin
      step();
      n++;
    end
  endtask

  function automatic int exp_result(input int s);
    return (s - 1) / CLK_DIV;
  endfunction

  // Full trial, stop sampled s edges after go (1 <= s <= TIMEOUT_MS*CLK_DIV).
  task automatic trial_normal(input string tag, input int s);
    int n;
    start = 1'b1;
    step();
    chk({tag, " busy"}, busy, 1);
    start = 1'b0;
    wait_go(0, n);
    chk({tag, " go_delay"}, n, DELAY_MIN * CLK_DIV);
    step(s - 1);
    stop = 1'b1;
    step();
    chk({tag, " result_ms"}, result_ms, exp_result(s));
    chk({tag, " result_valid"}, result_valid, 1);
    chk({tag, " go_low"}, go, 0);
    chk({tag, " flags"}, {early, timeout}, 0);
    stop = 1'b0;
    step();
    chk({tag, " valid_pulse"}, result_valid, 0);
    chk({tag, " result_held"}, result_ms, exp_result(s));
  endtask

  // Stop sampled a edges after ARMED entry (1 <= a <= DELAY_MIN*CLK_DIV).
  task automatic trial_early(input string tag, input int a);
    bit go_seen;
    go_seen = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (a - 1) begin
      step();
      if (go === 1'b1) go_seen = 1'b1;
    end
    stop = 1'b1;
    step();
    chk({tag, " early"}, early, 1);
    chk({tag, " result_ms"}, result_ms, 0);
    chk({tag, " result_valid"}, result_valid, 1);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " go_never"}, go_seen, 0);
    stop = 1'b0;
    step();
    chk({tag, " early_held"}, early, 1);
  endtask

  task automatic trial_rand_delay(input string tag, input int s);
    int n, d;
    d = DELAY_MIN + int'(m_lfsr[3:0]);
    start_r = 1'b1;
    step();
    chk({tag, " busy"}, busy_r, 1);
    start_r = 1'b0;
    wait_go(1, n);
    chk({tag, " go_delay"}, n, d * CLK_DIV);
    step(s - 1);
    stop_r = 1'b1;
    step();
    chk({tag, " result_ms"}, result_ms_r, exp_result(s));
    chk({tag, " result_valid"}, result_valid_r, 1);
    stop_r = 1'b0;
    step();
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, failed=%0d", failed);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed and randomized sequence
  // ---------------------------------------------------------------------------
  initial begin
    int n;
    int s;

    // Reset values.
    step(3);
    chk("rst go", go, 0);
    chk("rst busy", busy, 0);
    chk("rst result_ms", result_ms, 0);
    chk("rst result_valid", result_valid, 0);
    chk("rst early", early, 0);
    chk("rst timeout", timeout, 0);
    reset = 1'b0;
    step(2);

    // Stop in IDLE does nothing.
    stop = 1'b1;
    step();
    stop = 1'b0;
    step();
    chk("idle stop busy", busy, 0);
    chk("idle stop valid", result_valid, 0);

    // 1: normal trial, stop rises 12 clk after go.
    trial_normal("t1", 13);

    // 2: stop 8 clk into ARMED, and the boundary on the go edge.
    trial_early("t2", 9);
    trial_early("t2_edge", DELAY_MIN * CLK_DIV);

    // 3: no stop, timeout.
    start = 1'b1;
    step();
    start = 1'b0;
    wait_go(0, n);
    chk("t3 go_delay", n, DELAY_MIN * CLK_DIV);
    step(TIMEOUT_MS * CLK_DIV - 1);
    chk("t3 go_before", go, 1);
    step();
    chk("t3 go_after", go, 0);
    chk("t3 timeout", timeout, 1);
    chk("t3 result_ms", result_ms, TIMEOUT_MS);
    chk("t3 result_valid", result_valid, 1);
    step();
    chk("t3 valid_pulse", result_valid, 0);
    chk("t3 timeout_held", timeout, 1);

    // 4: stop coincident with the 3rd tick, plus window boundaries.
    trial_normal("t4", 12);
    trial_normal("t4_last", TIMEOUT_MS * CLK_DIV);
    trial_normal("t4_first", 1);

    // 5: start held for over 100 clk gives one trial only.
    start = 1'b1;
    step();
    chk("t5 busy", busy, 1);
    wait_go(0, n);
    chk("t5 go_delay", n, DELAY_MIN * CLK_DIV);
    step(TIMEOUT_MS * CLK_DIV);
    chk("t5 timeout", timeout, 1);
    step(20);
    chk("t5 no_retrigger", busy, 0);
    start = 1'b0;
    step();

    // 5: start pulse during GO is ignored.
    start = 1'b1;
    step();
    start = 1'b0;
    wait_go(0, n);
    step(2);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("t5 go_kept", go, 1);
    chk("t5 timeout_cleared", timeout, 0);
    stop = 1'b1;
    step();
    chk("t5 result_ms", result_ms, exp_result(5));
    stop = 1'b0;
    step();

    // Start and stop together in DONE: start wins, held stop gives no edge.
    start = 1'b1;
    stop  = 1'b1;
    step();
    chk("ss busy", busy, 1);
    start = 1'b0;
    wait_go(0, n);
    chk("ss go_delay", n, DELAY_MIN * CLK_DIV);
    chk("ss early", early, 0);
    stop = 1'b0;
    step(5);
    stop = 1'b1;
    step();
    chk("ss result_ms", result_ms, exp_result(6));
    stop = 1'b0;
    step();

    // Randomized trials.
    for (int i = 0; i < 10; i++) begin
      step($urandom_range(1, 5));
      if ($urandom_range(0, 2) == 0) trial_early("rnd_early", $urandom_range(1, DELAY_MIN * CLK_DIV));
      else                           trial_normal("rnd", $urandom_range(1, TIMEOUT_MS * CLK_DIV));
    end

    // 6: reset mid-GO.
    step(2);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_go(0, n);
    step(6);
    reset = 1'b1;
    #1;
    chk("t6 go", go, 0);
    chk("t6 busy", busy, 0);
    chk("t6 result_ms", result_ms, 0);
    chk("t6 result_valid", result_valid, 0);
    step(2);
    reset = 1'b0;
    step();
    chk("t6 idle", busy, 0);
    s = $urandom_range(1, TIMEOUT_MS * CLK_DIV);
    trial_normal("t6 after", s);

    // 6: random delay instance against the LFSR model.
    for (int i = 0; i < 5; i++) begin
      step($urandom_range(1, 9));
      trial_rand_delay("rdly", $urandom_range(1, 40));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
